// File: rtl/btn_multi_in.sv
// N-channel push-button front end: 2-flop sync, tick-sampled debounce, press/release/long-press pulses.
// Optional auto-repeat of press after a long press is built when BTN_REPEAT_EN is defined.
module btn_multi_in #(
    parameter int N            = 3,
    parameter int CLK_HZ       = 50000000,
    parameter int SAMPLE_HZ    = 40,
    parameter int STABLE       = 2,
    parameter int ACTIVE_LOW   = 1,
    parameter int LONG_TICKS   = 40,
    parameter int REPEAT_TICKS = 8
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic [N-1:0] btn,
    output logic [N-1:0] level,
    output logic [N-1:0] press,
    output logic [N-1:0] release_o,
    output logic [N-1:0] long_press,
    output logic         tick
);

    localparam int              DIV       = CLK_HZ / SAMPLE_HZ;
    localparam int              DIV_W     = $clog2(DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic            IDLE_BIT  = (ACTIVE_LOW != 0);
    localparam logic [N-1:0]    IDLE      = {N{IDLE_BIT}};
    localparam logic [3:0]      STAB_LAST = 4'(STABLE - 1);
    localparam logic [15:0]     LONG_MAX  = 16'(LONG_TICKS);
    localparam logic [15:0]     LONG_PRE  = 16'(LONG_TICKS - 1);

    if (DIV < 2 || STABLE < 1 || STABLE > 15 || LONG_TICKS < 1 || LONG_TICKS > 65535
        || REPEAT_TICKS < 1) begin : g_param_err
        $error("btn_multi_in: parameter out of range");
    end

    logic [N-1:0]       sync1_q, sync1_d;
    logic [N-1:0]       sync2_q, sync2_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               tick_q, tick_d;
    logic [N-1:0]       level_q, level_d;
    logic [N-1:0]       press_q, press_d;
    logic [N-1:0]       release_q, release_d;
    logic [N-1:0]       long_q, long_d;
    logic [N-1:0][3:0]  stab_q, stab_d;
    logic [N-1:0][15:0] hold_q, hold_d;
    logic [N-1:0]       s;

`ifdef BTN_REPEAT_EN
    localparam logic [15:0] REP_LAST = 16'(REPEAT_TICKS - 1);
    logic [N-1:0][15:0] rep_q, rep_d;
`endif

    // s = 1 means pressed regardless of pin polarity
    assign s = sync2_q ^ IDLE;

    always_comb begin
        sync1_d   = btn;
        sync2_d   = sync1_q;
        div_d     = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        tick_d    = (div_q == DIV_LAST);
        level_d   = level_q;
        stab_d    = stab_q;
        hold_d    = hold_q;
        press_d   = '0;
        release_d = '0;
        long_d    = '0;
`ifdef BTN_REPEAT_EN
        rep_d     = rep_q;
`endif
        if (tick_q) begin
            for (int i = 0; i < N; i++) begin
                if (s[i] == level_q[i]) begin
                    stab_d[i] = '0;
                end else if (stab_q[i] == STAB_LAST) begin
                    level_d[i] = ~level_q[i];
                    stab_d[i]  = '0;
                end else begin
                    stab_d[i] = stab_q[i] + 4'd1;
                end
                press_d[i]   = level_d[i] & ~level_q[i];
                release_d[i] = level_q[i] & ~level_d[i];

                // the rising tick sees level_q = 0, so it counts as hold 0
                if (!level_q[i]) begin
                    hold_d[i] = '0;
                end else if (hold_q[i] != LONG_MAX) begin
                    hold_d[i] = hold_q[i] + 16'd1;
                    long_d[i] = (hold_q[i] == LONG_PRE);
                end
`ifdef BTN_REPEAT_EN
                // repeats start once the hold count is saturated; suppressed on the falling tick
                if (!level_q[i] || !level_d[i]) begin
                    rep_d[i] = '0;
                end else if (hold_q[i] == LONG_MAX) begin
                    if (rep_q[i] == REP_LAST) begin
                        rep_d[i]   = '0;
                        press_d[i] = 1'b1;
                    end else begin
                        rep_d[i] = rep_q[i] + 16'd1;
                    end
                end
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            sync1_q   <= IDLE;
            sync2_q   <= IDLE;
            div_q     <= '0;
            tick_q    <= 1'b0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            long_q    <= '0;
            stab_q    <= '0;
            hold_q    <= '0;
`ifdef BTN_REPEAT_EN
            rep_q     <= '0;
`endif
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            div_q     <= div_d;
            tick_q    <= tick_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            stab_q    <= stab_d;
            hold_q    <= hold_d;
`ifdef BTN_REPEAT_EN
            rep_q     <= rep_d;
`endif
        end
    end

    assign level      = level_q;
    assign press      = press_q;
    assign release_o  = release_q;
    assign long_press = long_q;
    assign tick       = tick_q;

endmodule

// File: tb/tb_btn_multi_in.sv
// Bench for btn_multi_in: pulse events are predicted into a scoreboard queue as buttons are driven
// and matched (cycle + pulse vectors) by a negedge monitor. Honours BTN_REPEAT_EN.
module tb_btn_multi_in;

    localparam int LONG = 5;
    localparam int REP  = 2;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [2:0] btn = 3'b111;
    logic [2:0] level, press, release_o, long_press;
    logic       tick;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [31:0] c;
        logic [2:0]  p;
        logic [2:0]  r;
        logic [2:0]  l;
    } ev_t;

    ev_t sb[$];
    ev_t got_ev, exp_ev;

    btn_multi_in #(
        .N(3), .CLK_HZ(100), .SAMPLE_HZ(10), .STABLE(3), .ACTIVE_LOW(1),
        .LONG_TICKS(LONG), .REPEAT_TICKS(REP)
    ) dut (
        .clk(clk), .n_rst(n_rst), .btn(btn), .level(level), .press(press),
        .release_o(release_o), .long_press(long_press), .tick(tick)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic [2:0] p, input logic [2:0] r, input logic [2:0] l);
        sb.push_back({32'(c), p, r, l});
    endtask

    // any pulse must match the head of the scoreboard, cycle included
    always @(negedge clk) begin
        if (|(press | release_o | long_press) === 1'b1) begin
            got_ev = {32'(cyc), press, release_o, long_press};
            if (sb.size() == 0) begin
                chk("unexpected_pulse", 64'(got_ev), 64'(0));
            end else begin
                exp_ev = sb.pop_front();
                chk("pulse_event", 64'(got_ev), 64'(exp_ev));
            end
        end
    end

    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tick !== 1'b1 && n < 40);
        if (tick !== 1'b1) chk("tick_timeout", 64'(tick), 64'(1));
    endtask

    // press channels m on a tick cycle, release h ticks later; level moves 3 ticks + 1 clk after each edge
    task automatic hold_run(input logic [2:0] m, input int h);
        int c0;
        wait_tick();
        c0 = cyc;
        btn = btn & ~m;
        push(c0 + 31, m, 3'b000, 3'b000);
        for (int n = 1; n < h; n++) begin
            if (n == LONG) push(c0 + 31 + 10 * n, 3'b000, 3'b000, m);
`ifdef BTN_REPEAT_EN
            if (n > LONG && (n - LONG) % REP == 0) push(c0 + 31 + 10 * n, m, 3'b000, 3'b000);
`endif
        end
        repeat (3) wait_tick();
        chk("level_before_rise", 64'(level & m), 64'(0));
        @(negedge clk);
        chk("level_rise", 64'(level & m), 64'(m));
        repeat (h - 3) wait_tick();
        btn = btn | m;
        push(cyc + 31, 3'b000, m, 3'b000);
        repeat (3) wait_tick();
        chk("level_before_fall", 64'(level & m), 64'(m));
        @(negedge clk);
        chk("level_fall", 64'(level & m), 64'(0));
        repeat (2) wait_tick();
    endtask

    initial begin
        int n;
        int c0;
        int r;

        // 1: reset with idle pins, then tick cadence
        repeat (5) begin
            repeat (10) @(negedge clk);
            chk("reset_outputs", 64'({level, press, release_o, long_press, tick}), 64'(0));
        end
        n_rst = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tick !== 1'b1 && n < 30);
        chk("tick_first", 64'(n), 64'(10));
        repeat (3) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (tick !== 1'b1 && n < 30);
            chk("tick_period", 64'(n), 64'(10));
        end

        // 2: single press on channel 0
        hold_run(3'b001, 6);

        // 3: bounces on channel 1 never reach STABLE
        repeat (2) begin
            wait_tick();
            btn[1] = 1'b0;
            repeat (2) wait_tick();
            btn[1] = 1'b1;
            repeat (3) wait_tick();
            chk("bounce_level", 64'(level[1]), 64'(0));
        end

        // 4: channel 2 held 10 ticks
        hold_run(3'b100, 10);

        // 5: simultaneous press, then reset while still held
        wait_tick();
        c0 = cyc;
        btn = 3'b010;
        push(c0 + 31, 3'b101, 3'b000, 3'b000);
        repeat (3) wait_tick();
        @(negedge clk);
        chk("dual_level", 64'(level), 64'(3'b101));
        @(negedge clk);
        n_rst = 1'b0;
        @(negedge clk);
        r = cyc;
        n_rst = 1'b1;
        chk("midpress_reset_level", 64'({level, tick}), 64'(0));
        push(r + 31, 3'b101, 3'b000, 3'b000);
        repeat (3) wait_tick();
        chk("tick_after_reset", 64'(cyc), 64'(r + 30));
        @(negedge clk);
        chk("repress_level", 64'(level), 64'(3'b101));
        wait_tick();
        btn = 3'b111;
        push(cyc + 31, 3'b000, 3'b101, 3'b000);
        repeat (5) wait_tick();
        chk("dual_release_level", 64'(level), 64'(0));

        // 6: long hold on channel 1 (repeats only when BTN_REPEAT_EN is built)
        hold_run(3'b010, 15);
        repeat (3) wait_tick();

        chk("scoreboard_drain", 64'(sb.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
